// File: rtl/param_stack.sv
// Parametrised LIFO stack with a one-request-per-two-cycles control FSM.
// Optional STACK_CLEAR_EN macro adds a 'clear' input that empties the stack from IDLE.
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             user_push,
  input  logic             user_pop,
  input  logic [WIDTH-1:0] push_data,
`ifdef STACK_CLEAR_EN
  input  logic             clear,
`endif
  output logic             ready,
  output logic             done,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_REPL, S_OVF, S_UNF} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] data_q;
  logic [AW-1:0]    top_idx, wr_idx;
  logic             clr;

`ifdef STACK_CLEAR_EN
  assign clr = clear;
`else
  assign clr = 1'b0;
`endif

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // Only meaningful when non-empty / non-full; the FSM never uses them otherwise.
  assign top_idx = AW'(count - CW'(1));
  assign wr_idx  = AW'(count);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    if (state == S_IDLE && !clr) begin
      if (user_push && user_pop) state_nxt = empty ? S_UNF : S_REPL;
      else if (user_pop)         state_nxt = empty ? S_UNF : S_POP;
      else if (user_push)        state_nxt = full  ? S_OVF : S_PUSH;
    end
  end

  always_comb begin
    ready     = 1'b0;
    done      = 1'b0;
    pop_valid = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_PUSH:  done = 1'b1;
      S_POP:   begin done = 1'b1; pop_valid = 1'b1; end
      S_REPL:  begin done = 1'b1; pop_valid = 1'b1; end
      S_OVF:   overflow = 1'b1;
      S_UNF:   underflow = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign pop_data = pop_valid ? mem[top_idx] : '0;
  assign top      = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr)            count  <= '0;
          else if (user_push) data_q <= push_data;
        end
        S_PUSH:  count <= count + CW'(1);
        S_POP:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; reset only suppresses the abandoned write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_PUSH)      mem[wr_idx]  <= data_q;
      else if (state == S_REPL) mem[top_idx] <= data_q;
    end
  end
endmodule

// File: tb/tb_param_stack.sv
// Randomized scoreboard bench for param_stack (WIDTH=8, DEPTH=4) against a queue-based stack model.
module tb_param_stack;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         user_push = 1'b0, user_pop = 1'b0;
  logic [W-1:0] push_data = '0;
  logic         clear = 1'b0;
  logic         ready, done, pop_valid, empty, full, overflow, underflow;
  logic [W-1:0] pop_data, top;
  logic [2:0]   count;

  param_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .user_push(user_push), .user_pop(user_pop),
    .push_data(push_data),
`ifdef STACK_CLEAR_EN
    .clear(clear),
`endif
    .ready(ready), .done(done), .pop_valid(pop_valid), .pop_data(pop_data),
    .top(top), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    bit           dn, pv, ov, un;
    logic [W-1:0] pd;
  } exp_t;

  typedef enum {OP_NONE, OP_PUSH, OP_POP, OP_REPL} op_t;

  int           errors = 0, checks = 0, cyc = 0;
  exp_t         expq[$];
  logic [W-1:0] stk[$];
  bit           idle = 1'b1;
  op_t          pend = OP_NONE;
  logic [W-1:0] pend_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  // Monitor: any pulse/valid output must line up with the scoreboard head.
  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0].due == cyc) begin
      exp_t e;
      e = expq.pop_front();
      chk("done", 32'(done), 32'(e.dn));
      chk("pop_valid", 32'(pop_valid), 32'(e.pv));
      chk("pop_data", 32'(pop_data), 32'(e.pd));
      chk("overflow", 32'(overflow), 32'(e.ov));
      chk("underflow", 32'(underflow), 32'(e.un));
    end else if (done || pop_valid || overflow || underflow || pop_data != '0) begin
      chk("unexpected_pulse", {27'b0, done, pop_valid, overflow, underflow, |pop_data}, 32'd0);
    end
  end

  // One cycle, called at a negedge: check status vs model, drive inputs, advance model.
  task automatic step(input bit p, input bit po, input logic [W-1:0] d, input bit r, input bit c);
    exp_t e;
    chk("ready", 32'(ready), 32'(idle));
    chk("count", 32'(count), 32'(stk.size()));
    chk("top", 32'(top), stk.size() > 0 ? 32'(stk[$]) : 32'd0);
    chk("empty", 32'(empty), 32'(stk.size() == 0));
    chk("full", 32'(full), 32'(stk.size() == D));
    user_push = p; user_pop = po; push_data = d; reset = r; clear = c;
`ifndef STACK_CLEAR_EN
    c = 1'b0;
`endif
    if (r) begin
      stk.delete(); idle = 1'b1; pend = OP_NONE;
    end else if (!idle) begin
      case (pend)
        OP_PUSH: stk.push_back(pend_data);
        OP_POP:  void'(stk.pop_back());
        OP_REPL: stk[$] = pend_data;
        default: ;
      endcase
      pend = OP_NONE; idle = 1'b1;
    end else if (c) begin
      stk.delete();
    end else if (p || po) begin
      e = '{due: cyc + 1, dn: 0, pv: 0, ov: 0, un: 0, pd: '0};
      if (po && stk.size() == 0) e.un = 1;
      else if (po) begin
        e.dn = 1; e.pv = 1; e.pd = stk[$];
        pend = p ? OP_REPL : OP_POP;
      end else if (stk.size() == D) e.ov = 1;
      else begin
        e.dn = 1; pend = OP_PUSH;
      end
      pend_data = d;
      expq.push_back(e);
      idle = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic req(input bit p, input bit po, input logic [W-1:0] d);
    step(p, po, d, 0, 0);
    step(0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    // Underflow on empty, fill to full, overflow, drain.
    req(0, 1, 8'h00);
    req(1, 0, 8'hA1); req(1, 0, 8'hB2); req(1, 0, 8'hC3); req(1, 0, 8'hD4);
    req(1, 0, 8'hE5);
    repeat (4) req(0, 1, 8'h00);
    // Replace on non-empty, then replace/underflow on empty.
    req(1, 0, 8'h11); req(1, 0, 8'h22); req(1, 1, 8'h33);
    req(0, 1, 8'h00); req(0, 1, 8'h00);
    req(1, 1, 8'h44);
    // Request held while busy is dropped.
    step(1, 0, 8'h55, 0, 0); step(1, 0, 8'h66, 0, 0); step(0, 0, 8'h00, 0, 0);
    // Reset while a POP is in flight, and reset coinciding with a request.
    req(1, 0, 8'h77);
    step(0, 1, 8'h00, 0, 0); step(0, 0, 8'h00, 1, 0); step(0, 0, 8'h00, 0, 0);
    req(1, 0, 8'h88);
    step(0, 1, 8'h00, 1, 0); step(0, 0, 8'h00, 0, 0);
`ifdef STACK_CLEAR_EN
    req(1, 0, 8'h01); req(1, 0, 8'h02);
    step(1, 0, 8'h03, 0, 1); step(0, 0, 8'h00, 0, 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      bit fill;
      fill = ((i / 64) % 2) == 0;
      step($urandom_range(0, 99) < (fill ? 60 : 25),
           $urandom_range(0, 99) < (fill ? 20 : 55),
           W'($urandom),
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 39) == 0);
    end
    repeat (3) step(0, 0, 8'h00, 0, 0);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
